// File: rtl/booth_mac_accum.sv
// Purpose  : pipelined signed 8x8 Booth multiply-accumulate with a saturating dot-product accumulator.
// Latency  : pair accepted at edge E0 is summed at E2; a last term's result is on out_* after E2.
// Backpres.: out_valid & ~out_ready (or clr) drops in_ready and freezes every stage; no result is lost.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   clr                      flush of the in-flight vector (result register untouched)
//   in_valid/in_ready        operand handshake; in_a, in_b signed 8-bit; in_last ends a vector
//   out_valid/out_ready      result handshake; out_acc (ACC_W), out_count (CNT_W), out_sat

// Combinational radix-4 Booth multiplier, 8x8 signed -> 16-bit product.
module boothmul (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [8:0]  bx;
  logic [15:0] ax;
  logic [15:0] pp;
  logic [15:0] sum;

  always_comb begin
    bx  = {b, 1'b0};
    ax  = {{8{a[7]}}, a};
    sum = '0;
    pp  = '0;
    for (int i = 0; i < 4; i++) begin
      // Recode {b[2i+1], b[2i], b[2i-1]} into a digit in -2..+2.
      pp = '0;
      case (bx[2*i +: 3])
        3'b001, 3'b010: pp = ax;
        3'b011:         pp = ax << 1;
        3'b100:         pp = -(ax << 1);
        3'b101, 3'b110: pp = -ax;
        default:        pp = '0;
      endcase
      sum = sum + (pp << (2*i));
    end
    p = sum;
  end
endmodule

module booth_mac_accum #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);
  // S1: registered operands
  logic             v1, last1;
  logic [7:0]       a1, b1;
  // S2: registered product
  logic             v2, last2;
  logic [15:0]      prod2;
  logic [15:0]      prod;
  // S3: accumulator state
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             sat;
  logic             first;
  // result register
  logic [ACC_W-1:0] res_acc;
  logic [CNT_W-1:0] res_count;
  logic             res_sat;
  logic             res_vld;

  logic             adv;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum_w;
  logic             ovf;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_nxt;

  boothmul u_mul (.a(a1), .b(b1), .p(prod));

  assign adv      = ~clr & ~(res_vld & ~out_ready);
  assign in_ready = adv & ~rst;

  always_comb begin
    base  = first ? '0 : acc;
    sum_w = {base[ACC_W-1], base} + {{(ACC_W+1-16){prod2[15]}}, prod2};
    // The extra top bit disagreeing with the sign bit means the ACC_W result overflowed.
    ovf   = sum_w[ACC_W] ^ sum_w[ACC_W-1];
    if (ovf)
      acc_nxt = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_nxt = sum_w[ACC_W-1:0];
    if (first)
      cnt_nxt = CNT_W'(1);
    else if (&count)
      cnt_nxt = count;
    else
      cnt_nxt = count + 1'b1;
    sat_nxt = (first ? 1'b0 : sat) | ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      last1     <= 1'b0;
      a1        <= '0;
      b1        <= '0;
      v2        <= 1'b0;
      last2     <= 1'b0;
      prod2     <= '0;
      acc       <= '0;
      count     <= '0;
      sat       <= 1'b0;
      first     <= 1'b1;
      res_acc   <= '0;
      res_count <= '0;
      res_sat   <= 1'b0;
      res_vld   <= 1'b0;
    end else begin
      if (clr) begin
        v1    <= 1'b0;
        v2    <= 1'b0;
        acc   <= '0;
        count <= '0;
        sat   <= 1'b0;
        first <= 1'b1;
      end else if (adv) begin
        v1    <= in_valid;
        a1    <= in_a;
        b1    <= in_b;
        last1 <= in_last;
        v2    <= v1;
        prod2 <= prod;
        last2 <= last1;
        if (v2) begin
          acc   <= acc_nxt;
          count <= cnt_nxt;
          sat   <= sat_nxt;
          first <= last2;
        end
      end

      // A new result on the same edge as a consume keeps out_valid high with fresh data.
      if (adv && v2 && last2) begin
        res_acc   <= acc_nxt;
        res_count <= cnt_nxt;
        res_sat   <= sat_nxt;
        res_vld   <= 1'b1;
      end else if (out_ready) begin
        res_vld   <= 1'b0;
      end
    end
  end

  assign out_valid = res_vld;
  assign out_acc   = res_acc;
  assign out_count = res_count;
  assign out_sat   = res_sat;
endmodule
